mem_port_arbiter: RTL

Two-requester arbiter sharing the single-port 196608×16 on-chip CPU memory between the Nios CPU data master (port 0) and the DMA engine (port 1). It presents two Avalon-MM slave ports with waitrequest and pipelined readdatavalid, and drives one memory command per cycle. Arbitration is round-robin, with optional burst lock. It sits in the Qsys system between the interconnect and the memory wrapper.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/DMA on-chip memory port arbiter.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 18;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_DEPTH  = 196608;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: round-robin on ties, optionally holding the
// current owner for a burst (MEM_ARB_BURST_LOCK_EN).
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
`ifdef MEM_ARB_BURST_LOCK_EN
  input  logic [1:0] owner,
  input  logic [7:0] burst_cnt,
  input  logic [7:0] burst_max,
`endif
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
`ifdef MEM_ARB_BURST_LOCK_EN
    // Owner that is still requesting and below the burst limit keeps the port.
    if (owner == OWN_M0 && req[0] && burst_cnt < burst_max) begin
      gnt = 2'b01;
    end else if (owner == OWN_M1 && req[1] && burst_cnt < burst_max) begin
      gnt = 2'b10;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port Avalon-MM arbiter (CPU = port 0, DMA = port 1) in front of a
// single-port on-chip memory. Burst lock is compiled in with MEM_ARB_BURST_LOCK_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int BURST_LEN = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  input  logic [DATA_W-1:0]     mem_readdata,
  output logic                  arb_conflict,
  output logic [1:0]            dbg_owner
);

  owner_t                owner_q, owner_d;
  logic                  last_gnt_q, last_gnt_d;
  logic [1:0]            rd_pend_q, rd_pend_d;
  logic                  conflict_q, conflict_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W/8-1:0]   be_q, be_d;
  logic [DATA_W-1:0]     wd_q, wd_d;
  logic [1:0]            req;
  logic [1:0]            gnt;

  // Requests are masked in reset so nothing is granted while reset_n is low.
  assign req = {m1_read | m1_write, m0_read | m0_write} & {2{reset_n}};

`ifdef MEM_ARB_BURST_LOCK_EN
  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN - 1);
  logic [7:0] burst_cnt_q, burst_cnt_d;
  logic       retained;

  mem_arb_pick u_pick (
    .req       (req),
    .last_gnt  (last_gnt_q),
    .owner     (owner_q),
    .burst_cnt (burst_cnt_q),
    .burst_max (BURST_MAX),
    .gnt       (gnt)
  );

  always_comb begin
    retained    = (gnt[0] && owner_q == OWN_M0) || (gnt[1] && owner_q == OWN_M1);
    burst_cnt_d = 8'd0;
    if (retained) begin
      burst_cnt_d = (burst_cnt_q < BURST_MAX) ? burst_cnt_q + 8'd1 : burst_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) burst_cnt_q <= 8'd0;
    else          burst_cnt_q <= burst_cnt_d;
  end
`else
  mem_arb_pick u_pick (
    .req      (req),
    .last_gnt (last_gnt_q),
    .gnt      (gnt)
  );
`endif

  always_comb begin
    mem_write = 1'b0;
    addr_d    = addr_q;
    be_d      = be_q;
    wd_d      = wd_q;
    if (gnt[1]) begin
      addr_d    = m1_address;
      be_d      = m1_byteenable;
      wd_d      = m1_writedata;
      mem_write = m1_write;
    end else if (gnt[0]) begin
      addr_d    = m0_address;
      be_d      = m0_byteenable;
      wd_d      = m0_writedata;
      mem_write = m0_write;
    end
    if (!reset_n) begin
      addr_d = '0;
      be_d   = '0;
      wd_d   = '0;
    end
  end

  assign mem_chipselect = |gnt;
  assign mem_address    = addr_d;
  assign mem_byteenable = be_d;
  assign mem_writedata  = wd_d;
  assign m0_waitrequest = ~gnt[0];
  assign m1_waitrequest = ~gnt[1];

  always_comb begin
    owner_d = OWN_NONE;
    if (gnt[0])      owner_d = OWN_M0;
    else if (gnt[1]) owner_d = OWN_M1;
    last_gnt_d = last_gnt_q;
    if (gnt[1])      last_gnt_d = 1'b1;
    else if (gnt[0]) last_gnt_d = 1'b0;
    // A read+write command performs the write only, so it never returns data.
    rd_pend_d[0] = gnt[0] & m0_read & ~m0_write;
    rd_pend_d[1] = gnt[1] & m1_read & ~m1_write;
    conflict_d   = conflict_q | (m0_read & m0_write) | (m1_read & m1_write);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      owner_q    <= OWN_NONE;
      last_gnt_q <= 1'b1;
      rd_pend_q  <= 2'b00;
      conflict_q <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wd_q       <= '0;
    end else begin
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      rd_pend_q  <= rd_pend_d;
      conflict_q <= conflict_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wd_q       <= wd_d;
    end
  end

  assign m0_readdatavalid = rd_pend_q[0] & reset_n;
  assign m1_readdatavalid = rd_pend_q[1] & reset_n;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;
  assign arb_conflict     = conflict_q;
  assign dbg_owner        = owner_q;

endmodule
